// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the sync generator and the pixel generator.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Half-open window test lo <= val < hi on counter-width values.
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable and a terminal-count flag (high while Count == MODULUS-1).
module mod_counter #(
  parameter int MODULUS = 800,
  parameter int WIDTH   = 10
) (
  input  logic             Clock_In,
  input  logic             Reset_N,
  input  logic             Enable,
  output logic [WIDTH-1:0] Count,
  output logic             Terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign Terminal = (Count == LAST);

  always_ff @(posedge Clock_In) begin
    if (!Reset_N) begin
      Count <= '0;
    end else if (Enable) begin
      Count <= Terminal ? '0 : Count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: free-running H/V counters decoded into registered sync, visible flag,
// coordinates and line/frame start pulses, all one cycle behind the counters.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clock_In,
  input  logic       Reset_N,
  output logic       H_Sync,
  output logic       V_Sync,
  output logic       Video_On,
  output logic [9:0] X_Pos,
  output logic [9:0] Y_Pos,
  output logic       Line_Start,
  output logic       Frame_Start
);

  import vga_timing_pkg::*;

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_VIS_L = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_L = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_count_p0;
  logic [CNT_W-1:0] v_count_p0;
  logic             h_tc_p0;
  logic             v_tc_p0;
  logic             frame_first_p0;

  logic             visible_p0;
  logic             h_sync_n_p0;
  logic             v_sync_n_p0;
  logic             line_first_p0;

  logic             h_sync_p1;
  logic             v_sync_p1;
  logic             video_on_p1;
  logic [9:0]       x_pos_p1;
  logic [9:0]       y_pos_p1;
  logic             line_start_p1;
  logic             frame_start_p1;

  // ---- stage p0: pixel and line counters ----
  mod_counter #(.MODULUS(H_TOT), .WIDTH(CNT_W)) u_h_counter (
    .Clock_In (Clock_In),
    .Reset_N  (Reset_N),
    .Enable   (1'b1),
    .Count    (h_count_p0),
    .Terminal (h_tc_p0)
  );

  mod_counter #(.MODULUS(V_TOT), .WIDTH(CNT_W)) u_v_counter (
    .Clock_In (Clock_In),
    .Reset_N  (Reset_N),
    .Enable   (h_tc_p0),
    .Count    (v_count_p0),
    .Terminal (v_tc_p0)
  );

  // Set exactly while the counters sit at (0,0): after reset or after the joint wrap.
  always_ff @(posedge Clock_In) begin
    if (!Reset_N) begin
      frame_first_p0 <= 1'b1;
    end else begin
      frame_first_p0 <= h_tc_p0 & v_tc_p0;
    end
  end

  always_comb begin
    visible_p0    = (h_count_p0 < H_VIS_L) && (v_count_p0 < V_VIS_L);
    h_sync_n_p0   = !in_window(h_count_p0, H_SS, H_SE);
    v_sync_n_p0   = !in_window(v_count_p0, V_SS, V_SE);
    line_first_p0 = (h_count_p0 == '0);
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge Clock_In) begin
    if (!Reset_N) begin
      h_sync_p1      <= 1'b1;
      v_sync_p1      <= 1'b1;
      video_on_p1    <= 1'b0;
      x_pos_p1       <= '0;
      y_pos_p1       <= '0;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      h_sync_p1      <= h_sync_n_p0;
      v_sync_p1      <= v_sync_n_p0;
      video_on_p1    <= visible_p0;
      x_pos_p1       <= visible_p0 ? h_count_p0 : '0;
      y_pos_p1       <= visible_p0 ? v_count_p0 : '0;
      line_start_p1  <= line_first_p0;
      frame_start_p1 <= frame_first_p0;
    end
  end

  assign H_Sync      = h_sync_p1;
  assign V_Sync      = v_sync_p1;
  assign Video_On    = video_on_p1;
  assign X_Pos       = x_pos_p1;
  assign Y_Pos       = y_pos_p1;
  assign Line_Start  = line_start_p1;
  assign Frame_Start = frame_start_p1;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance for line timing and a shrunken instance
// (15x8 total) for frame wrap and mid-frame reset, checked through per-DUT scoreboards.
module tb_vga_sync_gen;

  localparam int END_CYC = 2410;

  logic Clock_In = 1'b0;
  logic rst_a_n  = 1'b0;
  logic rst_b_n  = 1'b0;

  logic       hs_a, vs_a, von_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, von_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;

  always #5 Clock_In = ~Clock_In;

  vga_sync_gen dut_a (
    .Clock_In    (Clock_In),
    .Reset_N     (rst_a_n),
    .H_Sync      (hs_a),
    .V_Sync      (vs_a),
    .Video_On    (von_a),
    .X_Pos       (x_a),
    .Y_Pos       (y_a),
    .Line_Start  (ls_a),
    .Frame_Start (fs_a)
  );

  // h: visible 0..7, sync 10..12, total 15; v: visible 0..3, sync 5..6, total 8
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_b (
    .Clock_In    (Clock_In),
    .Reset_N     (rst_b_n),
    .H_Sync      (hs_b),
    .V_Sync      (vs_b),
    .Video_On    (von_b),
    .X_Pos       (x_b),
    .Y_Pos       (y_b),
    .Line_Start  (ls_b),
    .Frame_Start (fs_b)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic       hs, vs, von;
    logic [9:0] x, y;
    logic       ls, fs;
  } vec_t;

  vec_t qa[$];
  vec_t qb[$];

  int applied     = 0;
  int miscompares = 0;

  task automatic push(input bit which, input int cyc, input string name,
                      input logic hs, input logic vs, input logic von,
                      input int x, input int y, input logic ls, input logic fs);
    vec_t v;
    v.cyc = cyc; v.name = name;
    v.hs = hs; v.vs = vs; v.von = von;
    v.x = 10'(x); v.y = 10'(y);
    v.ls = ls; v.fs = fs;
    if (which) qb.push_back(v);
    else       qa.push_back(v);
  endtask

  task automatic check_vec(input vec_t v, input logic hs, input logic vs, input logic von,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic ls, input logic fs);
    applied++;
    if ({hs, vs, von, x, y, ls, fs} !== {v.hs, v.vs, v.von, v.x, v.y, v.ls, v.fs}) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b want hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b",
               v.name, v.cyc, hs, vs, von, x, y, ls, fs,
               v.hs, v.vs, v.von, v.x, v.y, v.ls, v.fs);
    end
  endtask

  task automatic check_count(input string name, input int got, input int want);
    applied++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Stimulus: expected vectors are issued with the reset sequence that produces them.
  // Edge e counts rising edges from 0; both DUTs leave reset on edge 5, dut_b is reset
  // again on edge 40 (line 2, pixel 5) and restarts from (0,0) on edge 41.
  initial begin
    //        dut cyc   name            hs    vs    von   x    y  ls    fs
    push(0,    2, "a_rst_hold",     1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(0,    4, "a_rst_last",     1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(0,    5, "a_release",      1'b1, 1'b1, 1'b1,   0,   0, 1'b1, 1'b1);
    push(0,    6, "a_px1",          1'b1, 1'b1, 1'b1,   1,   0, 1'b0, 1'b0);
    push(0,  644, "a_px639",        1'b1, 1'b1, 1'b1, 639,   0, 1'b0, 1'b0);
    push(0,  645, "a_px640_blank",  1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(0,  660, "a_px655",        1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(0,  661, "a_hsync_fall",   1'b0, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(0,  756, "a_px751",        1'b0, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(0,  757, "a_hsync_rise",   1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(0,  804, "a_px799",        1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(0,  805, "a_line1_start",  1'b1, 1'b1, 1'b1,   0,   1, 1'b1, 1'b0);
    push(0, 1005, "a_l1_px200",     1'b1, 1'b1, 1'b1, 200,   1, 1'b0, 1'b0);
    push(0, 1605, "a_line2_start",  1'b1, 1'b1, 1'b1,   0,   2, 1'b1, 1'b0);

    push(1,    2, "b_rst_hold",     1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(1,    5, "b_release",      1'b1, 1'b1, 1'b1,   0,   0, 1'b1, 1'b1);
    push(1,   12, "b_px7",          1'b1, 1'b1, 1'b1,   7,   0, 1'b0, 1'b0);
    push(1,   13, "b_px8_blank",    1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(1,   15, "b_hsync_fall",   1'b0, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(1,   17, "b_px12",         1'b0, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(1,   18, "b_hsync_rise",   1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(1,   20, "b_line1_start",  1'b1, 1'b1, 1'b1,   0,   1, 1'b1, 1'b0);
    push(1,   40, "b_midframe_rst", 1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(1,   41, "b_restart",      1'b1, 1'b1, 1'b1,   0,   0, 1'b1, 1'b1);
    push(1,   44, "b_px3",          1'b1, 1'b1, 1'b1,   3,   0, 1'b0, 1'b0);
    push(1,   88, "b_l3_px2",       1'b1, 1'b1, 1'b1,   2,   3, 1'b0, 1'b0);
    push(1,  101, "b_l4_blank",     1'b1, 1'b1, 1'b0,   0,   0, 1'b1, 1'b0);
    push(1,  115, "b_l4_px14",      1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(1,  116, "b_vsync_fall",   1'b1, 1'b0, 1'b0,   0,   0, 1'b1, 1'b0);
    push(1,  145, "b_l6_px14",      1'b1, 1'b0, 1'b0,   0,   0, 1'b0, 1'b0);
    push(1,  146, "b_vsync_rise",   1'b1, 1'b1, 1'b0,   0,   0, 1'b1, 1'b0);
    push(1,  160, "b_last_px",      1'b1, 1'b1, 1'b0,   0,   0, 1'b0, 1'b0);
    push(1,  161, "b_frame_wrap",   1'b1, 1'b1, 1'b1,   0,   0, 1'b1, 1'b1);
    push(1,  162, "b_wrap_px1",     1'b1, 1'b1, 1'b1,   1,   0, 1'b0, 1'b0);
    push(1,  281, "b_frame_wrap2",  1'b1, 1'b1, 1'b1,   0,   0, 1'b1, 1'b1);

    repeat (5) @(negedge Clock_In);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (35) @(negedge Clock_In);
    rst_b_n = 1'b0;
    @(negedge Clock_In);
    rst_b_n = 1'b1;
  end

  // Monitor: samples both DUTs after every edge, pops due vectors, accumulates run counts.
  initial begin
    vec_t v;
    int von_cnt_a = 0, hs_lo_a = 0, ls_cnt_a = 0, fs_cnt_a = 0, vs_lo_a = 0, nz_a = 0;
    int von_cnt_b = 0, hs_lo_b = 0, ls_cnt_b = 0, fs_cnt_b = 0, vs_lo_b = 0, nz_b = 0;
    for (int e = 0; e < END_CYC; e++) begin
      @(posedge Clock_In);
      @(negedge Clock_In);
      if (qa.size() > 0 && qa[0].cyc == e) begin
        v = qa.pop_front();
        check_vec(v, hs_a, vs_a, von_a, x_a, y_a, ls_a, fs_a);
      end
      if (qb.size() > 0 && qb[0].cyc == e) begin
        v = qb.pop_front();
        check_vec(v, hs_b, vs_b, von_b, x_b, y_b, ls_b, fs_b);
      end
      if (e >= 5 && e <= 2404) begin
        if (von_a === 1'b1) von_cnt_a++;
        if (hs_a  === 1'b0) hs_lo_a++;
        if (vs_a  === 1'b0) vs_lo_a++;
        if (ls_a  === 1'b1) ls_cnt_a++;
        if (fs_a  === 1'b1) fs_cnt_a++;
      end
      if (e >= 41 && e <= 280) begin
        if (von_b === 1'b1) von_cnt_b++;
        if (hs_b  === 1'b0) hs_lo_b++;
        if (vs_b  === 1'b0) vs_lo_b++;
        if (ls_b  === 1'b1) ls_cnt_b++;
        if (fs_b  === 1'b1) fs_cnt_b++;
      end
      if (e >= 5 && von_a !== 1'b1 && (x_a !== 10'd0 || y_a !== 10'd0)) nz_a++;
      if (e >= 5 && von_b !== 1'b1 && (x_b !== 10'd0 || y_b !== 10'd0)) nz_b++;
    end

    // three full 800-cycle lines on the full-size timing
    check_count("a_video_on_cycles", von_cnt_a, 3 * 640);
    check_count("a_hsync_low_cycles", hs_lo_a, 3 * 96);
    check_count("a_vsync_low_cycles", vs_lo_a, 0);
    check_count("a_line_starts", ls_cnt_a, 3);
    check_count("a_frame_starts", fs_cnt_a, 1);
    check_count("a_blank_coords_nonzero", nz_a, 0);
    // two full 120-cycle frames on the shrunken timing
    check_count("b_video_on_cycles", von_cnt_b, 2 * 32);
    check_count("b_hsync_low_cycles", hs_lo_b, 16 * 3);
    check_count("b_vsync_low_cycles", vs_lo_b, 2 * 30);
    check_count("b_line_starts", ls_cnt_b, 16);
    check_count("b_frame_starts", fs_cnt_b, 2);
    check_count("b_blank_coords_nonzero", nz_b, 0);

    while (qa.size() > 0) begin
      v = qa.pop_front();
      applied++; miscompares++;
      $display("FAIL %s never reached got none want cyc %0d", v.name, v.cyc);
    end
    while (qb.size() > 0) begin
      v = qb.pop_front();
      applied++; miscompares++;
      $display("FAIL %s never reached got none want cyc %0d", v.name, v.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
